// File: rtl/logic_unit_pkg.sv
// Shared op-code constants for the logic unit pipeline and its combinational core.
// No logic here; constants only.
package logic_unit_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd3;
    localparam logic [OP_W-1:0] OP_ACC_OR = 3'd4;
endpackage

// File: rtl/logic_unit_core.sv
// Purpose: combinational bitwise op mux (AND/OR/XOR/NOR/ACC_OR), flags illegal op codes.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller owns the handshake.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W_P = OP_W
) (
    input  logic [OP_W_P-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  acc,
    output logic [WIDTH-1:0]  result,
    output logic              err
);
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_W_P'(OP_AND):    result = a & b;
            OP_W_P'(OP_OR):     result = a | b;
            OP_W_P'(OP_XOR):    result = a ^ b;
            OP_W_P'(OP_NOR):    result = ~(a | b);
            OP_W_P'(OP_ACC_OR): result = acc | a;
            default:            err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// Purpose: one-stage registered bitwise logic unit with OR-accumulate over multi-beat streams.
// Latency: one cycle from accept to out_valid; non-last ACC_OR beats produce no output.
// Backpressure: in_ready = !out_valid || out_ready, so a full register refills as it drains.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W_P = OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W_P-1:0] in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero,
    output logic              out_err
);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_result;
    logic             core_err;
    logic             accept;
    logic             is_acc;
    logic             produce;

    logic_unit_core #(.WIDTH(WIDTH), .OP_W_P(OP_W_P)) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .acc    (acc),
        .result (core_result),
        .err    (core_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_acc   = (in_op == OP_W_P'(OP_ACC_OR));
    // Only the closing beat of an accumulate stream emits a result.
    assign produce  = accept && (!is_acc || in_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            acc       <= '0;
        end else begin
            if (produce) begin
                out_valid <= 1'b1;
                out_data  <= core_result;
                out_zero  <= (core_result == '0);
                out_err   <= core_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Other ops leave acc alone so an interrupted stream can resume.
            if (accept && is_acc) begin
                acc <= in_last ? '0 : (acc | in_a);
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH=32 and WIDTH=8.
module tb_logic_unit_pipe;
    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_zero, out_err;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_data;

    logic        n_in_valid, n_in_ready, n_in_last, n_out_valid, n_out_ready, n_out_zero, n_out_err;
    logic [2:0]  n_in_op;
    logic [7:0]  n_in_a, n_in_b, n_out_data;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_err(out_err)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
        .in_a(n_in_a), .in_b(n_in_b), .in_last(n_in_last),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_zero(n_out_zero), .out_err(n_out_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_last  = last;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_op = 3'd0; n_in_a = '0; n_in_b = '0; n_in_last = 1'b0;
        n_out_ready = 1'b1;
        step(); step();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'h0);
        check("rst_zero", {31'b0, out_zero}, 32'd0);
        check("rst_err", {31'b0, out_err}, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back ops, no bubbles
        beat(3'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0); step();
        check("and_data", out_data, 32'h00F0_000F);
        check("and_valid", {31'b0, out_valid}, 32'd1);
        beat(3'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0); step();
        check("or_data", out_data, 32'hFFF0_0FFF);
        check("or_valid", {31'b0, out_valid}, 32'd1);
        beat(3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0); step();
        check("xor_data", out_data, 32'hFF00_0FF0);
        check("xor_valid", {31'b0, out_valid}, 32'd1);
        beat(3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0); step();
        check("nor_data", out_data, 32'h000F_F000);
        check("nor_err", {31'b0, out_err}, 32'd0);
        in_valid = 1'b0; step();
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        check("drain_hold", out_data, 32'h000F_F000);

        // ACC_OR stream
        beat(3'd4, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0); step();
        check("acc1_novalid", {31'b0, out_valid}, 32'd0);
        beat(3'd4, 32'h0000_0100, 32'h0, 1'b0); step();
        check("acc2_novalid", {31'b0, out_valid}, 32'd0);
        beat(3'd4, 32'h8000_0000, 32'h0, 1'b1); step();
        check("acc3_valid", {31'b0, out_valid}, 32'd1);
        check("acc3_data", out_data, 32'h8000_0101);
        check("acc3_zero", {31'b0, out_zero}, 32'd0);
        beat(3'd4, 32'h0000_0000, 32'h0, 1'b1); step();
        check("acc0_data", out_data, 32'h0);
        check("acc0_zero", {31'b0, out_zero}, 32'd1);
        check("acc0_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; step();

        // Backpressure
        out_ready = 1'b0;
        beat(3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0); step();
        check("bp_first", out_data, 32'h1234_5678);
        beat(3'd1, 32'h0000_0001, 32'h0000_0010, 1'b0); #1;
        check("bp_ready_low", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", out_data, 32'h1234_5678);
            check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1; #1;
        check("bp_ready_rise", {31'b0, in_ready}, 32'd1);
        step();
        check("bp_or_data", out_data, 32'h0000_0011);
        check("bp_or_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; step();

        // Illegal op mid-stream keeps acc
        beat(3'd4, 32'h0000_00F0, 32'h0, 1'b0); step();
        check("ill_pre_novalid", {31'b0, out_valid}, 32'd0);
        beat(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); step();
        check("ill_data", out_data, 32'h0);
        check("ill_zero", {31'b0, out_zero}, 32'd1);
        check("ill_err", {31'b0, out_err}, 32'd1);
        check("ill_valid", {31'b0, out_valid}, 32'd1);
        beat(3'd4, 32'h0000_000F, 32'h0, 1'b1); step();
        check("ill_resume_data", out_data, 32'h0000_00FF);
        check("ill_resume_err", {31'b0, out_err}, 32'd0);
        check("ill_resume_zero", {31'b0, out_zero}, 32'd0);

        // Reset mid-stream discards partial acc
        beat(3'd4, 32'h0000_0003, 32'h0, 1'b0); step();
        beat(3'd4, 32'h0000_0C00, 32'h0, 1'b0); step();
        in_valid = 1'b0; reset = 1'b1; step();
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_data", out_data, 32'h0);
        check("mrst_zero", {31'b0, out_zero}, 32'd0);
        check("mrst_err", {31'b0, out_err}, 32'd0);
        reset = 1'b0; step();
        check("mrst_ready", {31'b0, in_ready}, 32'd1);
        beat(3'd4, 32'h0000_0010, 32'h0, 1'b1); step();
        check("mrst_acc_data", out_data, 32'h0000_0010);
        check("mrst_acc_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; step();

        // WIDTH=8 instance
        n_in_valid = 1'b1; n_in_op = 3'd1; n_in_a = 8'hA5; n_in_b = 8'h5A; n_in_last = 1'b0;
        step();
        check("w8_or", {24'b0, n_out_data}, 32'h0000_00FF);
        check("w8_or_zero", {31'b0, n_out_zero}, 32'd0);
        n_in_op = 3'd3; step();
        check("w8_nor", {24'b0, n_out_data}, 32'h0);
        check("w8_nor_zero", {31'b0, n_out_zero}, 32'd1);
        check("w8_nor_valid", {31'b0, n_out_valid}, 32'd1);
        n_in_valid = 1'b0; step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
